// File: rtl/ram_burst_reader.sv
// Burst read master for a single-port, read-first, 1-cycle-latency coefficient RAM.
// Streams the words of a (base, count) burst in address order through a 3-entry output buffer.
module ram_burst_reader #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                 clock_i,
   input  logic                 reset_ni,
   input  logic                 start_i,
   input  logic [AW-1:0]        base_addr_i,
   input  logic [AW:0]          count_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ram_enable_o,
   output logic                 ram_write_en_o,
   output logic [AW-1:0]        ram_address_o,
   input  logic [MEM_WIDTH-1:0] ram_data_out_i,
   output logic                 out_valid_o,
   output logic [MEM_WIDTH-1:0] out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i
);

   localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_DEPTH - 1);
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ZERO = {(AW + 1){1'b0}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [AW:0]            cnt_q, cnt_d;
   logic [AW:0]            issued_q, issued_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic                   ren_q, ren_d;
   logic                   rlast_q, rlast_d;
   logic [AW-1:0]          raddr_q, raddr_d;
   logic                   inflight_q, inflight_d;
   logic                   inflight_last_q, inflight_last_d;
   logic [1:0]             occ_q, occ_d;
   logic [MEM_WIDTH-1:0]   buf_q [3];
   logic [MEM_WIDTH-1:0]   buf_d [3];
   logic                   last_q [3];
   logic                   last_d [3];
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pop_s;
   logic                   push_s;
   logic [1:0]             wr_idx_s;

   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      if (a == ADDR_MAX) begin
         return {AW{1'b0}};
      end else begin
         return a + AW'(1);
      end
   endfunction

   // Next-state: the issue decision for the next cycle is taken from next-cycle
   // occupancy/in-flight so that ram_enable itself leaves a register.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      pop_s           = valid_q & out_ready_i;
      push_s          = inflight_q;
      occ_d           = occ_q + {1'b0, push_s} - {1'b0, pop_s};
      inflight_d      = ren_q;
      inflight_last_d = ren_q & rlast_q;

      if (ren_q) begin
         issued_d = issued_q + CNT_ONE;
         addr_d   = addr_inc(addr_q);
      end else begin
         issued_d = issued_q;
         addr_d   = addr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cnt_d    = count_i;
               issued_d = CNT_ZERO;
               addr_d   = base_addr_i;
               busy_d   = 1'b1;
               state_d  = (count_i == CNT_ZERO) ? S_DRAIN : S_READ;
            end else begin
               busy_d   = 1'b0;
            end
         end
         S_READ: begin
            if (issued_d == cnt_q) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_READ;
            end
         end
         S_DRAIN: begin
            if (!inflight_d && (occ_d == 2'd0)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      ren_d   = (state_d == S_READ) && (issued_d < cnt_d) &&
                (({1'b0, occ_d} + {2'b00, inflight_d}) < 3'd3);
      rlast_d = ren_d && ((issued_d + CNT_ONE) == cnt_d);
      if (ren_d) begin
         raddr_d = addr_d;
      end else begin
         raddr_d = raddr_q;
      end
      valid_d = (occ_d != 2'd0);

      // Head always sits in entry 0 so the stream outputs come straight from a register.
      if (pop_s) begin
         buf_d[0]  = buf_q[1];
         buf_d[1]  = buf_q[2];
         buf_d[2]  = buf_q[2];
         last_d[0] = last_q[1];
         last_d[1] = last_q[2];
         last_d[2] = last_q[2];
         wr_idx_s  = occ_q - 2'd1;
      end else begin
         buf_d     = buf_q;
         last_d    = last_q;
         wr_idx_s  = occ_q;
      end
      if (push_s) begin
         case (wr_idx_s)
            2'd0: begin
               buf_d[0]  = ram_data_out_i;
               last_d[0] = inflight_last_q;
            end
            2'd1: begin
               buf_d[1]  = ram_data_out_i;
               last_d[1] = inflight_last_q;
            end
            2'd2: begin
               buf_d[2]  = ram_data_out_i;
               last_d[2] = inflight_last_q;
            end
            default: begin
               buf_d[0]  = buf_d[0];
            end
         endcase
      end else begin
         wr_idx_s = wr_idx_s;
      end
   end

   // State, buffer and registered outputs; reset discards any in-flight read.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q         <= S_IDLE;
         cnt_q           <= CNT_ZERO;
         issued_q        <= CNT_ZERO;
         addr_q          <= {AW{1'b0}};
         ren_q           <= 1'b0;
         rlast_q         <= 1'b0;
         raddr_q         <= {AW{1'b0}};
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         occ_q           <= 2'd0;
         valid_q         <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            buf_q[i]  <= {MEM_WIDTH{1'b0}};
            last_q[i] <= 1'b0;
         end
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         issued_q        <= issued_d;
         addr_q          <= addr_d;
         ren_q           <= ren_d;
         rlast_q         <= rlast_d;
         raddr_q         <= raddr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         occ_q           <= occ_d;
         valid_q         <= valid_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         for (int i = 0; i < 3; i++) begin
            buf_q[i]  <= buf_d[i];
            last_q[i] <= last_d[i];
         end
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign ram_enable_o   = ren_q;
   assign ram_write_en_o = 1'b0;
   assign ram_address_o  = raddr_q;
   assign out_valid_o    = valid_q;
   assign out_data_o     = buf_q[0];
   assign out_last_o     = last_q[0];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: directed test-plan bursts plus randomized bursts with random
// backpressure, scored against an address-order word queue built from (base, count).
module tb_ram_burst_reader;

   localparam int MW = 32;
   localparam int MD = 16;
   localparam int AW = 4;
   localparam int HN = 8192;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic          busy, done, ram_en, ram_we, out_valid, out_last;
   logic          out_ready = 1'b1;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_q = '0;
   logic [MW-1:0] out_data;
   logic [MW-1:0] mem [MD];

   exp_t exp_q [$];
   int   exp_a [$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, s_cyc = 0, done_cyc = 0, last_hs_cyc = 0;
   int n_en = 0, n_hs = 0, n_done = 0;
   int en_base = 0, hs_base = 0, done_base = 0;
   logic          prev_stall = 1'b0, prev_last = 1'b0;
   logic [MW-1:0] prev_data = '0;

   logic          busy_h  [HN];
   logic          en_h    [HN];
   logic          valid_h [HN];
   logic [MW-1:0] data_h  [HN];

   ram_burst_reader #(.MEM_WIDTH(MW), .MEM_DEPTH(MD)) dut (
      .clock_i        (clk),
      .reset_ni       (rst_n),
      .start_i        (start),
      .base_addr_i    (base_addr),
      .count_i        (count),
      .busy_o         (busy),
      .done_o         (done),
      .ram_enable_o   (ram_en),
      .ram_write_en_o (ram_we),
      .ram_address_o  (ram_addr),
      .ram_data_out_i (ram_q),
      .out_valid_o    (out_valid),
      .out_data_o     (out_data),
      .out_last_o     (out_last),
      .out_ready_i    (out_ready)
   );

   always #5 clk = ~clk;

   // Read-first single-port RAM, 1-cycle latency, output held when not enabled.
   always @(posedge clk) begin
      if (ram_en) ram_q <= mem[ram_addr];
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int first_en(input int from);
      for (int i = from; i < HN; i++) if (en_h[i]) return i - from;
      return -1;
   endfunction

   function automatic int first_valid(input int from);
      for (int i = from; i < HN; i++) if (valid_h[i]) return i - from;
      return -1;
   endfunction

   function automatic int count_set(input int from, input int to, input bit use_valid);
      int n = 0;
      for (int i = from; i <= to && i < HN; i++) begin
         if (use_valid ? valid_h[i] : en_h[i]) n++;
      end
      return n;
   endfunction

   // One clock cycle: sample at the falling edge, score, then step past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (cyc < HN) begin
         busy_h[cyc] = busy; en_h[cyc] = ram_en; valid_h[cyc] = out_valid; data_h[cyc] = out_data;
      end
      if (rst_n) begin
         if (ram_en) begin
            chk("outstanding_below_3", ((n_en - n_hs) < 3), 1);
            chk("ram_write_en", ram_we, 0);
            chk("read_expected", (exp_a.size() > 0), 1);
            if (exp_a.size() > 0) chk("ram_address", ram_addr, exp_a.pop_front());
            n_en++;
         end
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            chk("word_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", out_last, e.l);
            end
            n_hs++;
            last_hs_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic launch(input int b, input int c);
      exp_t e;
      start = 1'b1;
      base_addr = b[AW-1:0];
      count = c[AW:0];
      for (int i = 0; i < c; i++) begin
         e.d = 32'h100 + 32'((b + i) % MD);
         e.l = (i == c - 1);
         exp_q.push_back(e);
         exp_a.push_back((b + i) % MD);
      end
      s_cyc = cyc; done_base = n_done; en_base = n_en; hs_base = n_hs;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd_ready);
      int k = 0;
      while (n_done == done_base && k < budget) begin
         if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
         tick();
         k++;
      end
      chk("done_within_budget", (n_done != done_base), 1);
      out_ready = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ram_enable"}, ram_en, 0);
      chk({tag, "_ram_write_en"}, ram_we, 0);
      chk({tag, "_ram_address"}, ram_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
   endtask

   initial begin
      int b, c;
      for (int i = 0; i < MD; i++) mem[i] = 32'h100 + 32'(i);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Full-rate burst
      launch(2, 5);
      wait_done(50, 1'b0);
      chk("t1_done_cycle", done_cyc - s_cyc, 8);
      chk("t1_first_enable", first_en(s_cyc), 1);
      chk("t1_first_valid", first_valid(s_cyc), 3);
      chk("t1_last_handshake", last_hs_cyc - s_cyc, 7);
      chk("t1_busy_c0", busy_h[s_cyc], 0);
      chk("t1_busy_c1", busy_h[s_cyc + 1], 1);
      chk("t1_busy_c7", busy_h[s_cyc + 7], 1);
      chk("t1_busy_done", busy_h[s_cyc + 8], 0);
      chk("t1_words", n_hs - hs_base, 5);
      chk("t1_scoreboard_empty", exp_q.size(), 0);

      // Wrap-around
      launch(14, 4);
      wait_done(50, 1'b0);
      chk("t2_words", n_hs - hs_base, 4);
      chk("t2_reads", n_en - en_base, 4);
      chk("t2_addr_queue_empty", exp_a.size(), 0);

      // Backpressure
      out_ready = 1'b0;
      launch(0, 6);
      repeat (9) tick();
      out_ready = 1'b1;
      wait_done(60, 1'b0);
      chk("t3_reads_before_c10", count_set(s_cyc, s_cyc + 9, 1'b0), 3);
      chk("t3_valid_c10", valid_h[s_cyc + 10], 1);
      chk("t3_hold_c10", data_h[s_cyc + 10], 32'h100);
      chk("t3_done_after_last", done_cyc - last_hs_cyc, 1);
      chk("t3_words", n_hs - hs_base, 6);
      chk("t3_scoreboard_empty", exp_q.size(), 0);

      // Zero length
      launch(5, 0);
      wait_done(20, 1'b0);
      chk("t4_done_cycle", done_cyc - s_cyc, 2);
      chk("t4_busy_c1", busy_h[s_cyc + 1], 1);
      chk("t4_busy_c2", busy_h[s_cyc + 2], 0);
      chk("t4_no_reads", n_en - en_base, 0);
      chk("t4_no_valid", count_set(s_cyc, s_cyc + 2, 1'b1), 0);

      // Ignored second start
      launch(8, 4);
      tick();
      start = 1'b1; base_addr = 4'd1; count = 5'd9;
      tick();
      start = 1'b0;
      wait_done(50, 1'b0);
      repeat (5) tick();
      chk("t4_single_done", n_done - done_base, 1);
      chk("t4_words", n_hs - hs_base, 4);
      chk("t4_reads", n_en - en_base, 4);
      chk("t4_scoreboard_empty", exp_q.size(), 0);

      // Reset mid-burst
      launch(0, 8);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      tick();
      check_all_zero("midrst_hold");
      exp_q.delete(); exp_a.delete();
      n_en = 0; n_hs = 0; prev_stall = 1'b0;
      rst_n = 1'b1;
      launch(3, 2);
      wait_done(30, 1'b0);
      repeat (4) tick();
      chk("t5_words", n_hs - hs_base, 2);
      chk("t5_scoreboard_empty", exp_q.size(), 0);
      chk("t5_single_done", n_done - done_base, 1);

      // Randomized bursts with random backpressure
      for (int it = 0; it < 25; it++) begin
         b = $urandom_range(0, MD - 1);
         c = (it == 0) ? MD : $urandom_range(0, MD);
         out_ready = ($urandom_range(0, 1) != 0);
         launch(b, c);
         wait_done(600, 1'b1);
         chk("rnd_words", n_hs - hs_base, c);
         chk("rnd_reads", n_en - en_base, c);
         chk("rnd_scoreboard_empty", exp_q.size(), 0);
         if (c > 0) chk("rnd_done_after_last", done_cyc - last_hs_cyc, 1);
         else       chk("rnd_zero_done_cycle", done_cyc - s_cyc, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
